// File: rtl/usb2_in_responder_if.sv
// Buffer read port and TX byte stream between the IN responder, the endpoint
// buffer mux and the serializer.
interface usb2_in_responder_if;
  logic [8:0] buf_out_addr;
  logic [7:0] buf_out_q;
  logic [9:0] buf_out_len;
  logic       buf_out_hasdata;
  logic       buf_out_arm;
  logic       buf_out_arm_ack;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;

  modport master (
    output buf_out_addr, buf_out_arm, tx_valid, tx_data, tx_last,
    input  buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack, tx_ready
  );

  modport slave (
    input  buf_out_addr, buf_out_arm, tx_valid, tx_data, tx_last,
    output buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack, tx_ready
  );
endinterface

// File: rtl/usb2_in_responder.sv
// IN-token responder: answers an IN token with DATAx (PID, payload, CRC16), NAK or STALL,
// then waits for the host ACK and releases the endpoint buffer.
module usb2_in_responder #(
  parameter int MAX_PKT     = 512,
  parameter int RD_LAT      = 2,
  parameter int ACK_TIMEOUT = 96
) (
  input  logic                phy_clk,
  input  logic                reset,
  input  logic                i_in_token,
  input  logic [3:0]          i_in_endp,
  output logic                o_busy,
  output logic [3:0]          o_sel_endp,
  input  logic [1:0]          i_endp_mode,
  input  logic [1:0]          i_data_toggle,
  output logic                o_data_toggle_act,
  input  logic                i_host_ack,
  usb2_in_responder_if.master bus
);

  localparam int LAT_W = $clog2(RD_LAT + 2);
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 2);

  localparam logic [1:0] MODE_ISOCH = 2'd1;
  localparam logic [7:0] PID_STALL  = 8'h1E;
  localparam logic [7:0] PID_NAK    = 8'h5A;

  typedef enum logic [3:0] {
    S_IDLE, S_SEL, S_CHK, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_WAIT_ACK, S_ARM, S_HSK
  } state_t;

  state_t           r_state;
  logic [3:0]       r_sel_endp;
  logic [9:0]       r_cnt;
  logic [9:0]       r_len;
  logic [15:0]      r_crc;
  logic [LAT_W-1:0] r_wait;
  logic [TMR_W-1:0] r_timer;
  logic             r_iso;
  logic             r_zlp;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;
  logic             r_tx_last;
  logic             r_arm;
  logic             r_toggle_act;

  logic        w_hs;
  logic        w_iso;
  logic [9:0]  w_len_clamp;
  logic [7:0]  w_pid;
  logic [15:0] w_crc_next;

  // USB CRC16 in reflected form: poly 0x8005 bit-reversed is 0xA001, data enters LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {8'h00, d};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign w_hs        = r_tx_valid & bus.tx_ready;
  assign w_iso       = (i_endp_mode == MODE_ISOCH);
  assign w_len_clamp = (bus.buf_out_len > 10'(MAX_PKT)) ? 10'(MAX_PKT) : bus.buf_out_len;
  assign w_crc_next  = crc16_byte(r_crc, r_tx_data);

  always_comb begin
    unique case (i_data_toggle)
      2'd0:    w_pid = 8'hC3;
      2'd1:    w_pid = 8'h4B;
      2'd2:    w_pid = 8'h87;
      default: w_pid = 8'h0F;
    endcase
  end

  assign o_busy            = (r_state != S_IDLE);
  assign o_sel_endp        = r_sel_endp;
  assign o_data_toggle_act = r_toggle_act;
  assign bus.buf_out_addr  = r_cnt[8:0];
  assign bus.buf_out_arm   = r_arm;
  assign bus.tx_valid      = r_tx_valid;
  assign bus.tx_data       = r_tx_data;
  assign bus.tx_last       = r_tx_last;

  // NOTE: every state register uses <= so all branches read the pre-edge values consistently.
  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sel_endp   <= '0;
      r_cnt        <= '0;
      r_len        <= '0;
      r_crc        <= '0;
      r_wait       <= '0;
      r_timer      <= '0;
      r_iso        <= 1'b0;
      r_zlp        <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_tx_last    <= 1'b0;
      r_arm        <= 1'b0;
      r_toggle_act <= 1'b0;
    end else begin
      r_toggle_act <= 1'b0;
      if (r_wait != '0) r_wait <= r_wait - 1'b1;

      unique case (r_state)
        S_IDLE: begin
          if (i_in_token) begin
            r_sel_endp <= i_in_endp;
            r_state    <= S_SEL;
          end
        end

        S_SEL: r_state <= S_CHK;

        S_CHK: begin
          r_cnt      <= '0;
          r_crc      <= 16'hFFFF;
          r_iso      <= w_iso;
          r_zlp      <= ~bus.buf_out_hasdata;
          r_tx_valid <= 1'b1;
          if (r_sel_endp >= 4'd2) begin
            r_tx_data <= PID_STALL;
            r_tx_last <= 1'b1;
            r_state   <= S_HSK;
          end else if (!bus.buf_out_hasdata && !w_iso) begin
            r_tx_data <= PID_NAK;
            r_tx_last <= 1'b1;
            r_state   <= S_HSK;
          end else begin
            r_tx_data <= w_pid;
            r_len     <= bus.buf_out_hasdata ? w_len_clamp : 10'd0;
            r_wait    <= LAT_W'(RD_LAT);
            r_state   <= S_PID;
          end
        end

        S_PID: begin
          if (w_hs) begin
            if (r_len == 10'd0) begin
              r_tx_data <= ~r_crc[7:0];
              r_state   <= S_CRC_LO;
            end else begin
              r_tx_valid <= 1'b0;
              r_state    <= S_DATA;
            end
          end
        end

        // A byte is fetched only once the read pipeline has had RD_LAT cycles for the new address.
        S_DATA: begin
          if (!r_tx_valid) begin
            if (r_wait == '0) begin
              r_tx_valid <= 1'b1;
              r_tx_data  <= bus.buf_out_q;
            end
          end else if (w_hs) begin
            r_crc <= w_crc_next;
            r_cnt <= r_cnt + 10'd1;
            if (r_cnt + 10'd1 == r_len) begin
              r_tx_data <= ~w_crc_next[7:0];
              r_state   <= S_CRC_LO;
            end else begin
              r_tx_valid <= 1'b0;
              r_wait     <= LAT_W'(RD_LAT);
            end
          end
        end

        S_CRC_LO: begin
          if (w_hs) begin
            r_tx_data <= ~r_crc[15:8];
            r_tx_last <= 1'b1;
            r_state   <= S_CRC_HI;
          end
        end

        S_CRC_HI: begin
          if (w_hs) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_tx_last  <= 1'b0;
            r_timer    <= '0;
            if (r_iso) begin
              r_arm   <= ~r_zlp;
              r_state <= r_zlp ? S_IDLE : S_ARM;
            end else begin
              r_state <= S_WAIT_ACK;
            end
          end
        end

        // An ACK arriving on the expiry cycle still wins; on timeout the buffer stays armed for retry.
        S_WAIT_ACK: begin
          if (i_host_ack) begin
            r_toggle_act <= 1'b1;
            r_arm        <= 1'b1;
            r_state      <= S_ARM;
          end else if (r_timer == TMR_W'(ACK_TIMEOUT)) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_ARM: begin
          if (bus.buf_out_arm_ack) begin
            r_arm   <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_HSK: begin
          if (w_hs) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_tx_last  <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb2_in_responder.sv
// Self-checking bench for usb2_in_responder: table of IN transactions, timeout/retry,
// random back-pressure and mid-packet reset, all checked against a packet-level model.
module tb_usb2_in_responder;
  localparam int MAX_PKT     = 512;
  localparam int RD_LAT      = 2;
  localparam int ACK_TIMEOUT = 96;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [3:0] endp;
    logic [1:0] mode;
    bit         hasdata;
    int         len;
    logic [1:0] toggle;
    bit         ack;
    int         exp_arm;
    int         exp_tog;
    bit         exp_busy;
  } vec_t;

  logic       phy_clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_token = 1'b0;
  logic [3:0] in_endp = '0;
  logic       busy;
  logic [3:0] sel_endp;
  logic [1:0] endp_mode = '0;
  logic [1:0] data_toggle = '0;
  logic       toggle_act;
  logic       host_ack = 1'b0;

  usb2_in_responder_if bus ();

  usb2_in_responder #(.MAX_PKT(MAX_PKT), .RD_LAT(RD_LAT), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .phy_clk           (phy_clk),
    .reset             (reset),
    .i_in_token        (in_token),
    .i_in_endp         (in_endp),
    .o_busy            (busy),
    .o_sel_endp        (sel_endp),
    .i_endp_mode       (endp_mode),
    .i_data_toggle     (data_toggle),
    .o_data_toggle_act (toggle_act),
    .i_host_ack        (host_ack),
    .bus               (bus)
  );

  always #5 phy_clk = ~phy_clk;

  // Endpoint buffer: two register stages between address and data.
  logic [7:0] mem [0:511];
  logic [7:0] rd_d1;
  always @(posedge phy_clk) begin
    rd_d1         <= mem[bus.buf_out_addr];
    bus.buf_out_q <= rd_d1;
  end

  bit rand_ready = 1'b0;
  always @(posedge phy_clk) begin
    #1;
    bus.tx_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  int arm_hold = 0;
  always @(posedge phy_clk) begin
    #1;
    bus.buf_out_arm_ack = 1'b0;
    if (bus.buf_out_arm && !reset) begin
      arm_hold++;
      if (arm_hold == 3) begin
        bus.buf_out_arm_ack = 1'b1;
        arm_hold = 0;
      end
    end else begin
      arm_hold = 0;
    end
  end

  byte_q_t    got_q;
  bit         got_last[$];
  bit         last_seen = 1'b0;
  int         arm_rises = 0;
  int         tog_pulses = 0;
  int         stall_err = 0;
  logic       prev_arm = 1'b0;
  bit         pstall = 1'b0;
  logic [7:0] pdata;
  logic       plast;

  always @(negedge phy_clk) begin
    if (!reset) begin
      if (pstall && !(bus.tx_valid && bus.tx_data == pdata && bus.tx_last == plast)) stall_err++;
      if (bus.tx_valid && bus.tx_ready) begin
        got_q.push_back(bus.tx_data);
        got_last.push_back(bus.tx_last);
        if (bus.tx_last) last_seen = 1'b1;
      end
      if (bus.buf_out_arm && !prev_arm) arm_rises++;
      if (toggle_act) tog_pulses++;
      pstall = bus.tx_valid && !bus.tx_ready;
      pdata  = bus.tx_data;
      plast  = bus.tx_last;
    end else begin
      pstall = 1'b0;
    end
    prev_arm = bus.buf_out_arm;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // CRC16 computed bit-serially in the non-reflected register, then complemented and bit-reversed
  // so bit 0 of the result is the first bit on the wire.
  function automatic logic [15:0] crc_wire(input byte_q_t p);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    foreach (p[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = p[i][b] ^ c[15];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    c = ~c;
    for (int b = 0; b < 16; b++) r[b] = c[15-b];
    return r;
  endfunction

  task automatic build_expected(input vec_t v, output byte_q_t q);
    logic [7:0]  pid_tab [4];
    byte_q_t     pl;
    logic [15:0] cw;
    int          n;
    pid_tab = '{8'hC3, 8'h4B, 8'h87, 8'h0F};
    q = {};
    pl = {};
    if (v.endp >= 2) begin
      q.push_back(8'h1E);
    end else if (!v.hasdata && v.mode != 2'd1) begin
      q.push_back(8'h5A);
    end else begin
      n = v.hasdata ? ((v.len > MAX_PKT) ? MAX_PKT : v.len) : 0;
      for (int i = 0; i < n; i++) pl.push_back(mem[i]);
      cw = crc_wire(pl);
      q.push_back(pid_tab[v.toggle]);
      foreach (pl[i]) q.push_back(pl[i]);
      q.push_back(cw[7:0]);
      q.push_back(cw[15:8]);
    end
  endtask

  function automatic void derive(input vec_t v, output int ea, output int et, output bit eb);
    bit data_pkt;
    bit iso;
    iso      = (v.mode == 2'd1);
    data_pkt = (v.endp < 2) && (v.hasdata || iso);
    ea = (data_pkt && (iso ? v.hasdata : v.ack)) ? 1 : 0;
    et = (data_pkt && !iso && v.ack) ? 1 : 0;
    eb = data_pkt && !(iso && !v.hasdata);
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
  endtask

  task automatic run_txn(input string tag, input vec_t v, input int ack_delay, output int busy_cnt);
    byte_q_t exp_q;
    int      nbad;
    int      lbad;
    bit      timed_out;
    bus.buf_out_len     = 10'(v.len);
    bus.buf_out_hasdata = v.hasdata;
    endp_mode           = v.mode;
    data_toggle         = v.toggle;
    build_expected(v, exp_q);
    got_q = {};
    got_last = {};
    last_seen = 1'b0;
    arm_rises = 0;
    tog_pulses = 0;
    @(posedge phy_clk); #1;
    in_token = 1'b1;
    in_endp  = v.endp;
    @(posedge phy_clk); #1;
    in_token = 1'b0;
    in_endp  = 4'h0;
    @(negedge phy_clk);
    check({tag, " sel_endp"}, 32'(sel_endp), 32'(v.endp));
    timed_out = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(posedge phy_clk);
      if (last_seen) begin
        timed_out = 1'b0;
        break;
      end
    end
    check({tag, " last timeout"}, 32'(timed_out), 32'd0);
    @(negedge phy_clk);
    busy_cnt = busy ? 1 : 0;
    check({tag, " busy after last"}, 32'(busy), 32'(v.exp_busy));
    if (v.ack) begin
      repeat (ack_delay) @(posedge phy_clk);
      #1 host_ack = 1'b1;
      @(posedge phy_clk); #1;
      host_ack = 1'b0;
      @(negedge phy_clk);
    end
    for (int c = 0; c < 400 && busy; c++) begin
      @(negedge phy_clk);
      if (busy) busy_cnt++;
    end
    check({tag, " idle"}, 32'(busy), 32'd0);
    repeat (4) @(posedge phy_clk);
    check({tag, " length"}, 32'(got_q.size()), 32'(exp_q.size()));
    nbad = 0;
    lbad = 0;
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        if (got_q[i] !== exp_q[i]) nbad++;
        if (got_last[i] !== (i == exp_q.size() - 1)) lbad++;
      end
    end
    check({tag, " bad bytes"}, 32'(nbad), 32'd0);
    check({tag, " bad tx_last"}, 32'(lbad), 32'd0);
    check({tag, " arm count"}, 32'(arm_rises), 32'(v.exp_arm));
    check({tag, " toggle pulses"}, 32'(tog_pulses), 32'(v.exp_tog));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vec_t    vecs[9];
    vec_t    v;
    byte_q_t first_q;
    int      bc;
    bit      hit;

    vecs[0] = '{4'd1, 2'd2, 1'b1, 3,   2'd0, 1'b1, 1, 1, 1'b1};
    vecs[1] = '{4'd1, 2'd2, 1'b0, 3,   2'd0, 1'b0, 0, 0, 1'b0};
    vecs[2] = '{4'd2, 2'd2, 1'b1, 3,   2'd0, 1'b0, 0, 0, 1'b0};
    vecs[3] = '{4'd5, 2'd2, 1'b1, 3,   2'd0, 1'b0, 0, 0, 1'b0};
    vecs[4] = '{4'd1, 2'd1, 1'b0, 0,   2'd0, 1'b0, 0, 0, 1'b0};
    vecs[5] = '{4'd1, 2'd1, 1'b1, 20,  2'd3, 1'b0, 1, 0, 1'b1};
    vecs[6] = '{4'd0, 2'd0, 1'b1, 8,   2'd1, 1'b1, 1, 1, 1'b1};
    vecs[7] = '{4'd1, 2'd3, 1'b1, 0,   2'd2, 1'b1, 1, 1, 1'b1};
    vecs[8] = '{4'd0, 2'd0, 1'b0, 8,   2'd0, 1'b0, 0, 0, 1'b0};

    bus.buf_out_len     = '0;
    bus.buf_out_hasdata = 1'b0;
    bus.tx_ready        = 1'b1;
    bus.buf_out_arm_ack = 1'b0;
    fill_mem();
    #1;
    check("reset outputs", 32'({busy, sel_endp, toggle_act, bus.buf_out_addr, bus.buf_out_arm,
                                bus.tx_valid, bus.tx_data, bus.tx_last}), 32'd0);
    repeat (3) @(posedge phy_clk);
    @(negedge phy_clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      fill_mem();
      if (i == 0) begin
        mem[0] = 8'h01;
        mem[1] = 8'h02;
        mem[2] = 8'h03;
      end
      run_txn($sformatf("vec%0d", i), vecs[i], 2, bc);
    end

    // Oversized buffer, no host ACK: timeout without release, then an identical retry.
    fill_mem();
    v = '{4'd1, 2'd2, 1'b1, 600, 2'd1, 1'b0, 0, 0, 1'b1};
    run_txn("timeout", v, 0, bc);
    check("timeout busy cycles", 32'(bc), 32'(ACK_TIMEOUT + 1));
    first_q = got_q;
    v.ack = 1'b1; v.exp_arm = 1; v.exp_tog = 1;
    run_txn("retry", v, 3, bc);
    hit = (first_q == got_q);
    check("retry identical", 32'(hit), 32'd1);

    // ACK landing exactly on the expiry cycle.
    fill_mem();
    v = '{4'd1, 2'd2, 1'b1, 5, 2'd0, 1'b1, 1, 1, 1'b1};
    run_txn("ack at expiry", v, ACK_TIMEOUT, bc);

    // Random back-pressure with 64-byte payloads and random transactions.
    rand_ready = 1'b1;
    stall_err = 0;
    fill_mem();
    v = '{4'd1, 2'd2, 1'b1, 64, 2'd0, 1'b1, 1, 1, 1'b1};
    run_txn("stall64", v, 1, bc);
    for (int r = 0; r < 10; r++) begin
      fill_mem();
      v.endp    = 4'($urandom_range(0, 4));
      v.mode    = 2'($urandom_range(0, 3));
      v.hasdata = ($urandom_range(0, 3) != 0);
      v.len     = $urandom_range(0, 700);
      v.toggle  = 2'($urandom_range(0, 3));
      v.ack     = $urandom_range(0, 1);
      derive(v, v.exp_arm, v.exp_tog, v.exp_busy);
      run_txn($sformatf("rand%0d", r), v, $urandom_range(1, 5), bc);
    end
    check("stall stability", 32'(stall_err), 32'd0);

    // Reset in the middle of the payload, with a stray token while busy.
    fill_mem();
    bus.buf_out_len     = 10'd64;
    bus.buf_out_hasdata = 1'b1;
    endp_mode           = 2'd2;
    data_toggle         = 2'd0;
    got_q = {};
    @(posedge phy_clk); #1;
    in_token = 1'b1; in_endp = 4'd1;
    @(posedge phy_clk); #1;
    in_token = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge phy_clk);
      if (got_q.size() >= 10) begin
        hit = 1'b1;
        break;
      end
    end
    check("mid-data reached", 32'(hit), 32'd1);
    #1 in_token = 1'b1; in_endp = 4'd5;
    @(posedge phy_clk); #1;
    in_token = 1'b0; in_endp = 4'd0;
    @(negedge phy_clk);
    check("token ignored while busy", 32'(sel_endp), 32'd1);
    reset = 1'b1;
    #1;
    check("mid-reset outputs", 32'({busy, sel_endp, toggle_act, bus.buf_out_addr, bus.buf_out_arm,
                                    bus.tx_valid, bus.tx_data, bus.tx_last}), 32'd0);
    repeat (2) @(posedge phy_clk);
    @(negedge phy_clk);
    reset = 1'b0;
    arm_rises = 0;
    tog_pulses = 0;
    repeat (150) @(posedge phy_clk);
    check("post-reset arm", 32'(arm_rises), 32'd0);
    check("post-reset toggle", 32'(tog_pulses), 32'd0);
    check("post-reset busy", 32'(busy), 32'd0);
    rand_ready = 1'b0;

    fill_mem();
    v = '{4'd1, 2'd2, 1'b1, 17, 2'd1, 1'b1, 1, 1, 1'b1};
    run_txn("recover", v, 2, bc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
